// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: writeback beat layout, merge FSM states and byte-merge helper.
package riscv_v_pkg;

  localparam int RISCV_V_VLEN  = 128;
  localparam int RISCV_V_VLENB = RISCV_V_VLEN / 8;

  // Packed layout: data occupies the upper VLEN bits, valid mask the low VLENB bits.
  typedef struct packed {
    logic [RISCV_V_VLEN-1:0]  data;
    logic [RISCV_V_VLENB-1:0] valid;
  } riscv_v_wb_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } riscv_v_merge_state_e;

  function automatic logic [RISCV_V_VLEN-1:0] riscv_v_byte_merge(
    input logic [RISCV_V_VLEN-1:0]  old_line,
    input logic [RISCV_V_VLEN-1:0]  new_line,
    input logic [RISCV_V_VLENB-1:0] mask
  );
    logic [RISCV_V_VLEN-1:0] res;
    for (int i = 0; i < RISCV_V_VLENB; i++)
      res[8*i +: 8] = mask[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/riscv_v_byte_merge.sv
// Per-byte select between the old register line and the new writeback data.
module riscv_v_byte_merge #(
  parameter int VLEN = 128
) (
  input  logic [VLEN-1:0]   old_line,
  input  logic [VLEN-1:0]   new_line,
  input  logic [VLEN/8-1:0] mask,
  output logic [VLEN-1:0]   merged
);

  for (genvar i = 0; i < VLEN/8; i++) begin : g_byte
    assign merged[8*i +: 8] = mask[i] ? new_line[8*i +: 8] : old_line[8*i +: 8];
  end

endmodule

// File: rtl/riscv_v_wb_merge_unit.sv
// Vector writeback sink: merges masked bytes into a VRF line via read-modify-write,
// with a one-line cache of the last written register to skip the read on repeat hits.
module riscv_v_wb_merge_unit
  import riscv_v_pkg::*;
#(
  parameter int VLEN    = 128,
  parameter int VREG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [VREG_AW-1:0]       wb_vd,
  input  logic [VLEN+VLEN/8-1:0]   wb_data,
  output logic                     vrf_rd_en,
  output logic [VREG_AW-1:0]       vrf_rd_addr,
  input  logic [VLEN-1:0]          vrf_rd_data,
  output logic                     vrf_wr_en,
  output logic [VREG_AW-1:0]       vrf_wr_addr,
  output logic [VLEN-1:0]          vrf_wr_data,
  output logic                     busy
);

  localparam int VLENB = VLEN / 8;

  riscv_v_merge_state_e state_q, state_d;
  logic [VREG_AW-1:0] vd_q, vd_d;
  logic [VLEN-1:0]    data_q, data_d;
  logic [VLENB-1:0]   mask_q, mask_d;
  logic               hit_q, hit_d;
  logic               rd_en_q, rd_en_d;
  logic [VREG_AW-1:0] rd_addr_q, rd_addr_d;
  logic               wr_en_q, wr_en_d;
  logic [VREG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [VLEN-1:0]    wr_data_q, wr_data_d;
  logic               cache_vld_q, cache_vld_d;
  logic [VREG_AW-1:0] cache_vd_q, cache_vd_d;
  logic [VLEN-1:0]    cache_line_q, cache_line_d;

  logic [VLEN-1:0]  wb_new;
  logic [VLENB-1:0] wb_mask;
  logic             cache_hit;
  logic [VLEN-1:0]  merge_old;
  logic [VLEN-1:0]  merged;

  assign wb_new    = wb_data[VLEN+VLENB-1:VLENB];
  assign wb_mask   = wb_data[VLENB-1:0];
  assign cache_hit = cache_vld_q && (cache_vd_q == wb_vd);
  // Cache is coherent with the VRF because every write goes through WRITE.
  assign merge_old = hit_q ? cache_line_q : vrf_rd_data;

  riscv_v_byte_merge #(.VLEN(VLEN)) u_merge (
    .old_line (merge_old),
    .new_line (data_q),
    .mask     (mask_q),
    .merged   (merged)
  );

  always_comb begin
    state_d      = state_q;
    vd_d         = vd_q;
    data_d       = data_q;
    mask_d       = mask_q;
    hit_d        = hit_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cache_vld_d  = cache_vld_q;
    cache_vd_d   = cache_vd_q;
    cache_line_d = cache_line_q;

    if (flush) begin
      state_d     = IDLE;
      cache_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_valid && (wb_mask != '0)) begin
            vd_d   = wb_vd;
            data_d = wb_new;
            mask_d = wb_mask;
            if (&wb_mask) begin
              state_d   = WRITE;
              wr_en_d   = 1'b1;
              wr_addr_d = wb_vd;
              wr_data_d = wb_new;
            end else if (cache_hit) begin
              state_d = MERGE;
              hit_d   = 1'b1;
            end else begin
              state_d   = READ;
              hit_d     = 1'b0;
              rd_en_d   = 1'b1;
              rd_addr_d = wb_vd;
            end
          end
        end
        READ: state_d = MERGE;
        MERGE: begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = vd_q;
          wr_data_d = merged;
        end
        WRITE: begin
          state_d      = IDLE;
          cache_vld_d  = 1'b1;
          cache_vd_d   = wr_addr_q;
          cache_line_d = wr_data_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vd_q         <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      hit_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cache_vld_q  <= 1'b0;
      cache_vd_q   <= '0;
      cache_line_q <= '0;
    end else begin
      state_q      <= state_d;
      vd_q         <= vd_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      hit_q        <= hit_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cache_vld_q  <= cache_vld_d;
      cache_vd_q   <= cache_vd_d;
      cache_line_q <= cache_line_d;
    end
  end

  assign wb_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign vrf_rd_en   = rd_en_q;
  assign vrf_rd_addr = rd_addr_q;
  assign vrf_wr_en   = wr_en_q;
  assign vrf_wr_addr = wr_addr_q;
  assign vrf_wr_data = wr_data_q;

endmodule
